// File: rtl/dual_decode_queue.sv
// Two-wide in-order decode queue: up to 2 pushes and 0-2 pops per cycle, DEPTH-entry circular buffer.
// Outputs are registered-state only; define DDQ_NOP_SQUASH_EN to drop all-zero words on push.
`default_nettype none

module dual_decode_queue #(
    parameter int DEPTH = 12,
    parameter int WIDTH = 27
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [1:0]                     in_valid,
    input  logic [WIDTH-1:0]               in_data_0,
    input  logic [WIDTH-1:0]               in_data_1,
    output logic                           in_ready,
    output logic [WIDTH-1:0]               out_data_0,
    output logic [WIDTH-1:0]               out_data_1,
    output logic [1:0]                     out_valid,
    input  logic [1:0]                     pop_cnt,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W:0] DEPTH_P = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    logic             v0, v1;
    logic [1:0]       push_n, pop_req, pop_eff;
    logic [PTR_W-1:0] head_1, tail_1;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
        logic [PTR_W:0] s;
        s = {1'b0, p} + {{(PTR_W-1){1'b0}}, n};
        if (s >= DEPTH_P)
            s = s - DEPTH_P;
        return s[PTR_W-1:0];
    endfunction

`ifdef DDQ_NOP_SQUASH_EN
    assign v0 = in_valid[0] && (in_data_0 != '0);
    assign v1 = in_valid[1] && (in_data_1 != '0);
`else
    assign v0 = in_valid[0];
    assign v1 = in_valid[1];
`endif

    // Ready looks only at the pre-pop count so pop_cnt never reaches it.
    assign in_ready = (count <= CNT_W'(DEPTH-2));
    assign push_n   = in_ready ? ({1'b0, v0} + {1'b0, v1}) : 2'd0;
    assign head_1   = ptr_add(head, 2'd1);
    assign tail_1   = ptr_add(tail, 2'd1);

    always_comb begin
        pop_req = (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;
        pop_eff = pop_req;
        if (count == '0)
            pop_eff = 2'd0;
        else if (count == CNT_W'(1) && pop_req != 2'd0)
            pop_eff = 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= ptr_add(head, pop_eff);
            tail  <= ptr_add(tail, push_n);
            count <= count + CNT_W'(push_n) - CNT_W'(pop_eff);
        end
    end

    // Valid slots are compacted at the tail, older slot first.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && in_ready) begin
            if (v0 || v1)
                mem[tail] <= v0 ? in_data_0 : in_data_1;
            if (v0 && v1)
                mem[tail_1] <= in_data_1;
        end
    end

    assign out_valid[0] = (count >= CNT_W'(1));
    assign out_valid[1] = (count >= CNT_W'(2));
    assign out_data_0   = out_valid[0] ? mem[head]   : '0;
    assign out_data_1   = out_valid[1] ? mem[head_1] : '0;
    assign occupancy    = count;

endmodule

`default_nettype wire

// File: tb/tb_dual_decode_queue.sv
// Scoreboard bench for dual_decode_queue (DEPTH=12, WIDTH=27).
module tb_dual_decode_queue;

    localparam int DEPTH = 12;
    localparam int WIDTH = 27;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic [1:0]       in_valid = 2'b00;
    logic [WIDTH-1:0] in_data_0 = '0;
    logic [WIDTH-1:0] in_data_1 = '0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data_0, out_data_1;
    logic [1:0]       out_valid;
    logic [1:0]       pop_cnt = 2'd0;
    logic [3:0]       occupancy;

    int checks = 0;
    int failures = 0;
    logic [WIDTH-1:0] sb[$];

    dual_decode_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_data_0(in_data_0), .in_data_1(in_data_1),
        .in_ready(in_ready), .out_data_0(out_data_0), .out_data_1(out_data_1),
        .out_valid(out_valid), .pop_cnt(pop_cnt), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus and update the scoreboard at the edge.
    task automatic cycle(input logic [1:0] iv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [1:0] pc, input logic fl, input logic rn);
        int  n;
        bit  rdy, s0, s1;
        in_valid = iv; in_data_0 = a; in_data_1 = b; pop_cnt = pc; flush = fl; rst_n = rn;
        @(posedge clk);
        if (!rn || fl) begin
            sb.delete();
        end else begin
            rdy = (sb.size() <= DEPTH-2);
            n = (pc == 2'd3) ? 2 : int'(pc);
            if (n > sb.size()) n = sb.size();
            for (int i = 0; i < n; i++) void'(sb.pop_front());
            s0 = iv[0]; s1 = iv[1];
`ifdef DDQ_NOP_SQUASH_EN
            if (a == '0) s0 = 1'b0;
            if (b == '0) s1 = 1'b0;
`endif
            if (rdy && s0) sb.push_back(a);
            if (rdy && s1) sb.push_back(b);
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(2'b00, '0, '0, 2'd0, 1'b0, 1'b0);
        cycle(2'b00, '0, '0, 2'd0, 1'b0, 1'b0);
        cycle(2'b00, '0, '0, 2'd0, 1'b0, 1'b1);
        checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL reset_out_valid got=%b want=00", out_valid); end
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL reset_occupancy got=%0d want=0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_data_0 !== '0) begin failures++; $display("FAIL reset_out_data_0 got=%h want=0", out_data_0); end
        checks++; if (out_data_1 !== '0) begin failures++; $display("FAIL reset_out_data_1 got=%h want=0", out_data_1); end
    endtask

    task automatic test_ordering();
        logic [WIDTH-1:0] a = 27'h0000A01, b = 27'h0000B02, c = 27'h0000C03, d = 27'h0000D04;
        cycle(2'b11, a, b, 2'd0, 1'b0, 1'b1);
        cycle(2'b11, c, d, 2'd0, 1'b0, 1'b1);
        checks++; if (occupancy !== 4'd4) begin failures++; $display("FAIL order_occ got=%0d want=4", occupancy); end
        checks++; if (out_data_0 !== a || out_data_1 !== b) begin failures++; $display("FAIL order_ab got=%h,%h want=%h,%h", out_data_0, out_data_1, a, b); end
        cycle(2'b00, '0, '0, 2'd1, 1'b0, 1'b1);
        checks++; if (out_data_0 !== b || out_data_1 !== c) begin failures++; $display("FAIL order_bc got=%h,%h want=%h,%h", out_data_0, out_data_1, b, c); end
        cycle(2'b00, '0, '0, 2'd2, 1'b0, 1'b1);
        checks++; if (out_data_0 !== d || out_valid !== 2'b01) begin failures++; $display("FAIL order_d got=%h/%b want=%h/01", out_data_0, out_valid, d); end
        checks++; if (out_data_1 !== '0) begin failures++; $display("FAIL order_nop1 got=%h want=0", out_data_1); end
        cycle(2'b00, '0, '0, 2'd1, 1'b0, 1'b1);
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL order_drain got=%0d want=0", occupancy); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++)
            cycle(2'b11, WIDTH'(32'h100 + 2*i), WIDTH'(32'h101 + 2*i), 2'd0, 1'b0, 1'b1);
        cycle(2'b01, 27'h1AA, 27'h1BB, 2'd0, 1'b0, 1'b1);
        checks++; if (occupancy !== 4'd11) begin failures++; $display("FAIL full_occ got=%0d want=11", occupancy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
        cycle(2'b11, 27'h2CC, 27'h2DD, 2'd0, 1'b0, 1'b1);
        checks++; if (occupancy !== 4'd11) begin failures++; $display("FAIL full_ignore got=%0d want=11", occupancy); end
        cycle(2'b00, '0, '0, 2'd1, 1'b0, 1'b1);
        checks++; if (occupancy !== 4'd10 || in_ready !== 1'b1) begin failures++; $display("FAIL full_pop1 got=%0d/%b want=10/1", occupancy, in_ready); end
        checks++; if (out_data_0 !== 27'h101) begin failures++; $display("FAIL full_head got=%h want=101", out_data_0); end
        for (int i = 0; i < 8 && sb.size() > 0; i++) cycle(2'b00, '0, '0, 2'd3, 1'b0, 1'b1);
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL full_drain got=%0d want=0", occupancy); end
    endtask

    task automatic test_wrap_overpop();
        logic [WIDTH-1:0] e0, e1;
        int nxt = 1;
        int bad = 0;
        for (int i = 0; i < 3*DEPTH; i++) begin
            cycle(2'b11, WIDTH'(nxt), WIDTH'(nxt+1), 2'($urandom_range(0, 3)), 1'b0, 1'b1);
            if (in_ready || i == 0) nxt += 2;
            if (sb.size() == 0) nxt = nxt;
            e0 = (sb.size() >= 1) ? sb[0] : '0;
            e1 = (sb.size() >= 2) ? sb[1] : '0;
            checks++;
            if (out_data_0 !== e0 || out_data_1 !== e1 || occupancy !== 4'(sb.size())) begin
                failures++; bad++;
                if (bad < 5) $display("FAIL wrap_step%0d got=%h,%h occ=%0d want=%h,%h occ=%0d",
                                      i, out_data_0, out_data_1, occupancy, e0, e1, sb.size());
            end
        end
        for (int i = 0; i < 16 && sb.size() > 1; i++) cycle(2'b00, '0, '0, 2'd1, 1'b0, 1'b1);
        checks++; if (occupancy !== 4'd1) begin failures++; $display("FAIL overpop_setup got=%0d want=1", occupancy); end
        cycle(2'b00, '0, '0, 2'd2, 1'b0, 1'b1);
        checks++; if (occupancy !== 4'd0 || out_valid !== 2'b00) begin failures++; $display("FAIL overpop got=%0d/%b want=0/00", occupancy, out_valid); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) cycle(2'b11, WIDTH'(32'h300 + 2*i), WIDTH'(32'h301 + 2*i), 2'd0, 1'b0, 1'b1);
        checks++; if (occupancy !== 4'd6) begin failures++; $display("FAIL flush_setup got=%0d want=6", occupancy); end
        cycle(2'b11, 27'h3EE, 27'h3FF, 2'd2, 1'b1, 1'b1);
        checks++; if (occupancy !== 4'd0 || out_valid !== 2'b00) begin failures++; $display("FAIL flush got=%0d/%b want=0/00", occupancy, out_valid); end
        for (int i = 0; i < 3; i++) cycle(2'b11, WIDTH'(32'h400 + 2*i), WIDTH'(32'h401 + 2*i), 2'd0, 1'b0, 1'b1);
        cycle(2'b11, 27'h4EE, 27'h4FF, 2'd2, 1'b1, 1'b0);
        checks++; if (occupancy !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1 || out_data_0 !== '0)
            begin failures++; $display("FAIL rst_flush got=%0d/%b/%b/%h want=0/00/1/0", occupancy, out_valid, in_ready, out_data_0); end
        cycle(2'b00, '0, '0, 2'd0, 1'b0, 1'b1);
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL rst_flush_idle got=%0d want=0", occupancy); end
    endtask

    task automatic test_compaction();
        logic [WIDTH-1:0] x = 27'h5A5A5A5, z = 27'h6B6B6B6, y = 27'h7C7C7C7;
        cycle(2'b10, 27'h1111111, x, 2'd0, 1'b0, 1'b1);
        checks++; if (out_data_0 !== x || occupancy !== 4'd1) begin failures++; $display("FAIL compact_10 got=%h/%0d want=%h/1", out_data_0, occupancy, x); end
        cycle(2'b01, z, 27'h2222222, 2'd0, 1'b0, 1'b1);
        checks++; if (out_data_1 !== z || out_valid !== 2'b11) begin failures++; $display("FAIL compact_01 got=%h/%b want=%h/11", out_data_1, out_valid, z); end
        cycle(2'b00, '0, '0, 2'd2, 1'b0, 1'b1);
        cycle(2'b11, '0, y, 2'd0, 1'b0, 1'b1);
`ifdef DDQ_NOP_SQUASH_EN
        checks++; if (occupancy !== 4'd1 || out_data_0 !== y) begin failures++; $display("FAIL squash got=%0d/%h want=1/%h", occupancy, out_data_0, y); end
`else
        checks++; if (occupancy !== 4'd2 || out_data_1 !== y || out_data_0 !== '0) begin failures++; $display("FAIL nosquash got=%0d/%h,%h want=2/0,%h", occupancy, out_data_0, out_data_1, y); end
`endif
        checks++; if (occupancy !== 4'(sb.size())) begin failures++; $display("FAIL squash_model got=%0d want=%0d", occupancy, sb.size()); end
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_full();
        test_wrap_overpop();
        test_flush();
        test_compaction();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dual_decode_queue.md
# dual_decode_queue

Two-wide in-order queue between the decode stage (two `ControlCenter` instances) and the dual-issue scheduler. Each cycle it accepts up to two 27-bit decoded-instruction words in program order. It presents the two oldest entries to the scheduler and retires 0, 1 or 2 of them per cycle, as the scheduler reports. It replaces the single-width decode FIFO, with defined full/empty, simultaneous push/pop and flush behaviour.

## Interface
Parameters:
- `DEPTH`, 12: number of entries; even, ≥ 4.
- `WIDTH`, 27: entry width. Layout is rs1[26:22], rs2[21:17], rd[16:12], ALUsel[11:8], wen[7], WBSel[6], ALUSrc[5], branch[4], memwriteen[3], uses_rd[2], uses_rs1[1], uses_rs2[0].

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `flush` in 1: discard all entries (branch redirect).
- `in_valid` in 2: bit0 = older decode slot, bit1 = younger slot.
- `in_data_0` in WIDTH: older decoded word.
- `in_data_1` in WIDTH: younger decoded word.
- `in_ready` out 1: high when at least 2 entries are free.
- `out_data_0` out WIDTH: oldest entry (head).
- `out_data_1` out WIDTH: second-oldest entry (head+1).
- `out_valid` out 2: bit0 = out_data_0 valid, bit1 = out_data_1 valid.
- `pop_cnt` in 2: entries consumed by the scheduler this cycle (0, 1 or 2); value 3 is treated as 2.
- `occupancy` out $clog2(DEPTH+1): current entry count.

## Operation
- Storage is a circular buffer of DEPTH registers with a head pointer, a tail pointer and a count. Both pointers wrap from DEPTH-1 to 0.
- Push:
  - A push happens only when `in_ready` is 1. When `in_ready` is 0, in_valid is ignored and no data is written.
  - The valid slots are compacted at the tail, oldest first.
  - 2'b11: write in_data_0 at tail and in_data_1 at tail+1; tail advances by 2.
  - 2'b01: write in_data_0 at tail; tail advances by 1.
  - 2'b10: write in_data_1 at tail; tail advances by 1.
  - 2'b00: no write.
- Pop:
  - The effective pop is min(pop_cnt, occupancy), so over-pop saturates and never underflows.
  - Head advances by the effective pop.
- Push and pop in the same cycle: count_next = count + pushed − popped.
- `in_ready` is computed from the current (pre-pop) count: count ≤ DEPTH−2. Same-cycle pops do not raise it. This keeps it free of any combinational path from pop_cnt.
- Outputs:
  - out_valid[0] = (count ≥ 1); out_valid[1] = (count ≥ 2).
  - out_data_n is driven from storage when its valid bit is set, and is 0 (nop) otherwise.
- Flush:
  - Flush sets head, tail and count to 0 and ignores any push or pop in that cycle.
  - rst_n has priority over flush.
- Reset: head = tail = count = 0; out_valid = 2'b00; out_data_0 and out_data_1 = 0; in_ready = 1; occupancy = 0. Storage contents are don't-care.

## Timing
- Push-to-visibility latency is 1 cycle: data pushed at edge N appears on out_data at edge N when the queue was empty, i.e. it is valid during cycle N+1.
- out_data, out_valid, in_ready and occupancy depend only on registered state. There is no combinational path from any input to any output.
- pop_cnt is sampled at the rising edge. The scheduler must drive it from the out_valid/out_data values it saw in the same cycle.
- Wrap case: with tail = DEPTH−1, a 2'b11 push writes index DEPTH−1 and index 0, and tail becomes 1.
- Likewise, with head = DEPTH−1, out_data_1 reads index 0.
- A reset or flush asserted mid-stream takes effect at the next edge; from the following cycle, outputs show the empty state.

## Configuration
- `DDQ_NOP_SQUASH_EN` defined: on push, a slot whose word is all-zero is treated as invalid and is not stored. For example, in_valid = 2'b11 with in_data_0 = 0 stores only in_data_1, and tail advances by 1. Unrecognised or empty decodes therefore never occupy scheduler slots.
- Undefined: every valid slot is stored regardless of contents.

## Test plan
- Reset then idle: rst_n = 0 for 2 cycles, then 1 → out_valid = 00, occupancy = 0, in_ready = 1, out_data_0 = 0.
- Ordering:
  - Push pairs (A, B) then (C, D) with pop_cnt = 0 → occupancy = 4, out_data_0 = A, out_data_1 = B.
  - Then pop_cnt = 1 → next cycle out_data_0 = B, out_data_1 = C.
  - Then pop_cnt = 2 → next cycle out_data_0 = D, out_valid = 01.
- Full:
  - Push 2'b11 pairs until occupancy = DEPTH−1 (push 2'b01 last) → in_ready = 0.
  - Further pushes are ignored and occupancy stays 11 (DEPTH = 12).
  - Pop 1 → occupancy 10 and in_ready = 1 the next cycle.
- Wrap and over-pop:
  - Push and pop continuously for 3×DEPTH cycles with incrementing data → outputs are strictly in order across the pointer wrap.
  - pop_cnt = 2 with occupancy = 1 → occupancy = 0, no underflow.
- Flush:
  - With occupancy = 6, assert flush together with an in_valid = 11 push and pop_cnt = 2 → occupancy = 0 and out_valid = 00 next cycle.
  - In the same setup, rst_n = 0 and flush together → state equals reset.
- Compaction and squash:
  - in_valid = 10 with data X → out_data_0 = X.
  - With `DDQ_NOP_SQUASH_EN` defined, push (0, Y) with in_valid = 11 → occupancy += 1 and Y is at the tail.
